// File: rtl/rx_frame_buf_ctrl_if.sv
// Bus bundle for the RX frame buffer write sequencer: MAC halfword stream in,
// port-A write port out, head-slot status and release toward the host.
interface rx_frame_buf_ctrl_if #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned SLOT_AW   = 10,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned CNT_W     = 16
);
    logic                           rx_valid;
    logic [15:0]                    rx_data;
    logic                           rx_last;
    logic                           rx_last_odd;
    logic                           rx_err;
    logic                           mem_en;
    logic [1:0]                     mem_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic [15:0]                    mem_din;
    logic                           frame_avail;
    logic [$clog2(NUM_SLOTS)-1:0]   frame_slot;
    logic [SLOT_AW:0]               frame_len;
    logic                           frame_release;
    logic [$clog2(NUM_SLOTS):0]     slot_count;
    logic [CNT_W-1:0]               drop_cnt;

    modport master (
        output rx_valid, rx_data, rx_last, rx_last_odd, rx_err, frame_release,
        input  mem_en, mem_we, mem_addr, mem_din, frame_avail, frame_slot, frame_len,
               slot_count, drop_cnt
    );

    modport slave (
        input  rx_valid, rx_data, rx_last, rx_last_odd, rx_err, frame_release,
        output mem_en, mem_we, mem_addr, mem_din, frame_avail, frame_slot, frame_len,
               slot_count, drop_cnt
    );
endinterface

// File: rtl/rx_frame_buf_ctrl.sv
// Write-side sequencer for the widening RX frame buffer: places MAC halfwords into a
// ring of fixed-size slots, captures per-slot lengths and drops full/oversize/bad frames.
module rx_frame_buf_ctrl #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned SLOT_AW   = 10,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned CNT_W     = 16
) (
    input logic               clk,
    input logic               rst,
    rx_frame_buf_ctrl_if.slave bus
);
    localparam int unsigned SlotW = $clog2(NUM_SLOTS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRecv = 2'd1;
    localparam logic [1:0] StDrop = 2'd2;

    localparam logic [SLOT_AW:0] SlotFull = {1'b1, {SLOT_AW{1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [SLOT_AW:0]   offset_q, offset_d;
    logic [SlotW-1:0]   tail_q, tail_d;
    logic [SlotW-1:0]   head_q, head_d;
    logic [SlotW:0]     count_q, count_d;
    logic [SLOT_AW:0]   len_q [NUM_SLOTS];
    logic [SLOT_AW:0]   len_d [NUM_SLOTS];
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               mem_en_q, mem_en_d;
    logic [1:0]         mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [15:0]        mem_din_q, mem_din_d;

    logic               wr;
    logic               commit;
    logic               drop_inc;
    logic               release_ok;
    logic               ring_full;
    logic [SLOT_AW:0]   beats;
    logic [SLOT_AW:0]   len_new;

    assign ring_full  = (count_q == (SlotW + 1)'(NUM_SLOTS));
    assign release_ok = bus.frame_release && (count_q != '0);
    assign beats      = offset_q + (SLOT_AW + 1)'(1);
    assign len_new    = {beats[SLOT_AW-1:0], 1'b0} - {{SLOT_AW{1'b0}}, bus.rx_last_odd};

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        tail_d     = tail_q;
        head_d     = head_q;
        count_d    = count_q;
        len_d      = len_q;
        drop_cnt_d = drop_cnt_q;
        wr         = 1'b0;
        commit     = 1'b0;
        drop_inc   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    if (ring_full) begin
                        if (bus.rx_last) drop_inc = 1'b1;
                        else             state_d  = StDrop;
                    end else begin
                        wr       = 1'b1;
                        offset_d = (SLOT_AW + 1)'(1);
                        if (bus.rx_last) begin
                            offset_d = '0;
                            if (bus.rx_err) drop_inc = 1'b1;
                            else            commit   = 1'b1;
                        end else begin
                            state_d = StRecv;
                        end
                    end
                end
            end
            StRecv: begin
                if (bus.rx_valid) begin
                    if (offset_q == SlotFull) begin
                        offset_d = '0;
                        if (bus.rx_last) begin
                            drop_inc = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            state_d = StDrop;
                        end
                    end else begin
                        wr       = 1'b1;
                        offset_d = beats;
                        if (bus.rx_last) begin
                            offset_d = '0;
                            state_d  = StIdle;
                            if (bus.rx_err) drop_inc = 1'b1;
                            else            commit   = 1'b1;
                        end
                    end
                end
            end
            StDrop: begin
                if (bus.rx_valid && bus.rx_last) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A frame only starts when count < NUM_SLOTS, so commit never overflows count.
        if (commit) begin
            len_d[tail_q] = len_new;
            tail_d        = tail_q + SlotW'(1);
        end
        if (release_ok) head_d = head_q + SlotW'(1);

        case ({commit, release_ok})
            2'b10:   count_d = count_q + (SlotW + 1)'(1);
            2'b01:   count_d = count_q - (SlotW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);

        mem_en_d   = wr;
        mem_we_d   = 2'b00;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (wr) begin
            mem_we_d   = (bus.rx_last && bus.rx_last_odd) ? 2'b01 : 2'b11;
            mem_addr_d = {tail_q, offset_q[SLOT_AW-1:0]};
            mem_din_d  = bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            offset_q   <= '0;
            tail_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            len_q      <= '{default: '0};
            drop_cnt_q <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 2'b00;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            tail_q     <= tail_d;
            head_q     <= head_d;
            count_q    <= count_d;
            len_q      <= len_d;
            drop_cnt_q <= drop_cnt_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;
    assign bus.frame_avail = (count_q != '0);
    assign bus.frame_slot  = head_q;
    assign bus.frame_len   = len_q[head_q];
    assign bus.slot_count  = count_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_rx_frame_buf_ctrl.sv
// Randomized self-checking bench for rx_frame_buf_ctrl against a frame-level ring model.
module tb_rx_frame_buf_ctrl;
    localparam int NS  = 8;
    localparam int SAW = 10;
    localparam int AW  = 13;
    localparam int CW  = 16;
    localparam int SW  = 3;
    localparam int STW = 1 + SW + (SAW + 1) + (SW + 1) + CW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_frame_buf_ctrl_if #(.NUM_SLOTS(NS), .SLOT_AW(SAW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    rx_frame_buf_ctrl #(.NUM_SLOTS(NS), .SLOT_AW(SAW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Frame-level model of the ring.
    int m_head, m_tail, m_count, m_drop;
    int m_len [NS];

    function automatic logic [STW-1:0] exp_status();
        return {m_count != 0, SW'(m_head), (SAW + 1)'(m_len[m_head]), (SW + 1)'(m_count),
                CW'(m_drop)};
    endfunction

    function automatic logic [STW-1:0] obs_status();
        return {bus.frame_avail, bus.frame_slot, bus.frame_len, bus.slot_count, bus.drop_cnt};
    endfunction

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_count = 0; m_drop = 0;
        for (int i = 0; i < NS; i++) m_len[i] = 0;
    endtask

    task automatic idle_inputs();
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_last = 1'b0;
        bus.rx_last_odd = 1'b0; bus.rx_err = 1'b0; bus.frame_release = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_release();
        bus.frame_release = 1'b1;
        @(posedge clk); #1;
        bus.frame_release = 1'b0;
        if (m_count > 0) begin
            m_head  = (m_head + 1) % NS;
            m_count = m_count - 1;
        end
    endtask

    // Drives one frame beat by beat and checks every port-A cycle against the model.
    task automatic send_frame(input int n, input bit odd, input bit err, input bit rel_last,
                              input string tag);
        bit       full;
        bit       rel_ok;
        int       tail0;
        bit       exp_wr;
        logic [1:0]  exp_we;
        logic [15:0] d;
        full  = (m_count == NS);
        tail0 = m_tail;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                bus.rx_valid = 1'b0; bus.frame_release = 1'b0;
                @(posedge clk); #1;
                total++;
                if (bus.mem_en !== 1'b0 || bus.mem_we !== 2'b00) begin
                    bad++;
                    $display("FAIL %s gap beat %0d: en=%b we=%b want en=0 we=00",
                             tag, i, bus.mem_en, bus.mem_we);
                end
            end
            d = 16'($urandom);
            bus.rx_valid      = 1'b1;
            bus.rx_data       = d;
            bus.rx_last       = (i == n - 1);
            bus.rx_last_odd   = (i == n - 1) ? odd : 1'($urandom);
            bus.rx_err        = (i == n - 1) ? err : 1'($urandom);
            bus.frame_release = (i == n - 1) && rel_last;
            exp_wr = !full && (i < 1024);
            exp_we = ((i == n - 1) && odd) ? 2'b01 : 2'b11;
            rel_ok = (i == n - 1) && rel_last && (m_count > 0);
            @(posedge clk); #1;
            total++;
            if (exp_wr) begin
                if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !==
                    {1'b1, exp_we, AW'(tail0 * 1024 + i), d}) begin
                    bad++;
                    $display("FAIL %s write %0d: en=%b we=%b addr=%h din=%h want en=1 we=%b addr=%h din=%h",
                             tag, i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din,
                             exp_we, AW'(tail0 * 1024 + i), d);
                end
            end else if (bus.mem_en !== 1'b0 || bus.mem_we !== 2'b00) begin
                bad++;
                $display("FAIL %s nowrite %0d: en=%b we=%b want en=0 we=00",
                         tag, i, bus.mem_en, bus.mem_we);
            end
        end
        idle_inputs();
        if (full || n > 1024 || err) begin
            if (m_drop < 65535) m_drop++;
        end else begin
            m_len[m_tail] = (2 * n - int'(odd)) & 2047;
            m_tail  = (m_tail + 1) % NS;
            m_count = m_count + 1;
        end
        if (rel_ok) begin
            m_head  = (m_head + 1) % NS;
            m_count = m_count - 1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !== '0) begin
            bad++;
            $display("FAIL reset_mem: en=%b we=%b addr=%h din=%h want all 0",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        total++;
        if (obs_status() !== '0) begin
            bad++;
            $display("FAIL reset_status: got=%h want=0", obs_status());
        end
    endtask

    task automatic test_even_frame();
        send_frame(32, 1'b0, 1'b0, 1'b0, "even64");
        total++;
        if (obs_status() !== exp_status() || bus.frame_len !== 11'd64) begin
            bad++;
            $display("FAIL even64_status: got=%h want=%h", obs_status(), exp_status());
        end
    endtask

    task automatic test_odd_frame();
        send_frame(31, 1'b1, 1'b0, 1'b0, "odd61");
        do_release();
        total++;
        if (obs_status() !== exp_status() || bus.frame_len !== 11'd61) begin
            bad++;
            $display("FAIL odd61_status: got=%h want=%h", obs_status(), exp_status());
        end
    endtask

    task automatic test_full_ring();
        apply_reset();
        for (int f = 0; f < NS; f++)
            send_frame(int'($urandom_range(1, 20)), 1'($urandom), 1'b0, 1'b0, "fill");
        total++;
        if (obs_status() !== exp_status()) begin
            bad++;
            $display("FAIL full_status: got=%h want=%h", obs_status(), exp_status());
        end
        send_frame(5, 1'b0, 1'b0, 1'b0, "full_multi");
        send_frame(1, 1'b1, 1'b0, 1'b0, "full_single");
        total++;
        if (obs_status() !== exp_status() || bus.drop_cnt !== 16'd2) begin
            bad++;
            $display("FAIL full_drop: got=%h want=%h", obs_status(), exp_status());
        end
        do_release();
        total++;
        if (obs_status() !== exp_status() || bus.frame_slot !== 3'd1) begin
            bad++;
            $display("FAIL full_release: got=%h want=%h", obs_status(), exp_status());
        end
        send_frame(7, 1'b1, 1'b0, 1'b0, "after_full");
        total++;
        if (obs_status() !== exp_status()) begin
            bad++;
            $display("FAIL after_full_status: got=%h want=%h", obs_status(), exp_status());
        end
    endtask

    task automatic test_oversize();
        apply_reset();
        send_frame(3, 1'b0, 1'b0, 1'b0, "pre_big");
        send_frame(1030, 1'b0, 1'b0, 1'b0, "big1030");
        send_frame(1025, 1'b1, 1'b0, 1'b0, "big1025");
        total++;
        if (obs_status() !== exp_status()) begin
            bad++;
            $display("FAIL oversize_status: got=%h want=%h", obs_status(), exp_status());
        end
        send_frame(4, 1'b0, 1'b0, 1'b0, "post_big");
        total++;
        if (obs_status() !== exp_status()) begin
            bad++;
            $display("FAIL post_big_status: got=%h want=%h", obs_status(), exp_status());
        end
    endtask

    task automatic test_err_and_empty_release();
        send_frame(9, 1'b1, 1'b1, 1'b0, "err");
        total++;
        if (obs_status() !== exp_status()) begin
            bad++;
            $display("FAIL err_status: got=%h want=%h", obs_status(), exp_status());
        end
        while (m_count > 0) do_release();
        do_release();
        total++;
        if (obs_status() !== exp_status() || bus.frame_avail !== 1'b0) begin
            bad++;
            $display("FAIL empty_release: got=%h want=%h", obs_status(), exp_status());
        end
    endtask

    task automatic test_commit_release();
        apply_reset();
        for (int f = 0; f < 3; f++)
            send_frame(int'($urandom_range(2, 12)), 1'($urandom), 1'b0, 1'b0, "cr_fill");
        send_frame(6, 1'b0, 1'b0, 1'b1, "cr_same");
        total++;
        if (obs_status() !== exp_status() || bus.slot_count !== 4'd3) begin
            bad++;
            $display("FAIL commit_release: got=%h want=%h", obs_status(), exp_status());
        end
        send_frame(3, 1'b1, 1'b0, 1'b0, "cr_next");
        total++;
        if (obs_status() !== exp_status()) begin
            bad++;
            $display("FAIL cr_next_status: got=%h want=%h", obs_status(), exp_status());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            bus.rx_valid = 1'b1; bus.rx_data = 16'($urandom); bus.rx_last = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        total++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !== '0 || obs_status() !== '0) begin
            bad++;
            $display("FAIL reset_mid: en=%b we=%b addr=%h status=%h want all 0",
                     bus.mem_en, bus.mem_we, bus.mem_addr, obs_status());
        end
        send_frame(5, 1'b1, 1'b0, 1'b0, "post_rst");
        total++;
        if (obs_status() !== exp_status()) begin
            bad++;
            $display("FAIL post_rst_status: got=%h want=%h", obs_status(), exp_status());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            send_frame(int'($urandom_range(1, 48)), 1'($urandom),
                       ($urandom_range(0, 7) == 0), 1'($urandom), "rand");
            if ($urandom_range(0, 2) == 0) do_release();
            total++;
            if (obs_status() !== exp_status()) begin
                bad++;
                $display("FAIL rand_status %0d: got=%h want=%h", f, obs_status(), exp_status());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_even_frame();
        test_odd_frame();
        test_full_ring();
        test_oversize();
        test_err_and_empty_release();
        test_commit_release();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_frame_buf_ctrl.md
Name: rx_frame_buf_ctrl

Overview:
Write-side sequencer for the 16-bit/64-bit widening RX frame buffer. It takes the MAC receive halfword stream and generates port-A address, data and byte-enables. The buffer is managed as a ring of NUM_SLOTS fixed-size frame slots with per-slot length capture. It exposes head-slot status to the host side, which reads the frame over port B and releases the slot; full-ring, oversize and errored frames are dropped and counted.

Parameters:
NUM_SLOTS, 8, frame slots in ring; power of two, 2..8
SLOT_AW, 10, halfword address bits per slot (1024 halfwords = 2048 bytes)
ADDR_W, 13, port-A halfword address width; must equal log2(NUM_SLOTS)+SLOT_AW
CNT_W, 16, width of dropped-frame counter

Ports:
clk  in  1  sole clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  halfword beat valid (no backpressure)
rx_data  in  16  beat data; byte 0 in [7:0]
rx_last  in  1  final beat of frame, qualified by rx_valid
rx_last_odd  in  1  on last beat only [7:0] valid
rx_err  in  1  frame error (FCS/PHY), sampled on last beat
mem_en  out  1  port-A enable
mem_we  out  2  port-A byte write enables
mem_addr  out  ADDR_W  port-A halfword address
mem_din  out  16  port-A write data
frame_avail  out  1  at least one committed slot
frame_slot  out  log2(NUM_SLOTS)  head slot index
frame_len  out  SLOT_AW+1  head frame byte length
frame_release  in  1  one-cycle pulse: host done with head slot
slot_count  out  log2(NUM_SLOTS)+1  committed slots
drop_cnt  out  CNT_W  dropped frames, saturating

Behaviour:
- Reset: all outputs 0; head=tail=count=0; all slot lengths 0; state IDLE; drop_cnt 0.
- mem_* are registered: accepted beat appears on mem_* exactly 1 cycle later, mem_en=1 for that cycle only. mem_addr = {tail, offset}. mem_we=2'b11, except last beat with rx_last_odd: 2'b01. Non-beat cycles: mem_en=0, mem_we=0.
- States: IDLE, RECV, DROP.
- IDLE + rx_valid: if count==NUM_SLOTS -> no write; if rx_last, drop_cnt++ and stay IDLE, else DROP. Otherwise write at offset 0, offset<=1; if rx_last then commit-check (below) and stay IDLE, else RECV.
- RECV + rx_valid: if offset==2^SLOT_AW (slot full) -> no write, DROP (or if rx_last: drop_cnt++, IDLE). Else write at offset, offset++; on rx_last: commit-check, IDLE.
- DROP: swallow beats, no writes; on rx_valid&&rx_last: drop_cnt++, IDLE.
- Commit-check on last beat: rx_err=1 -> drop_cnt++, no commit (slot data overwritten by next frame). Else len[tail] <= 2*beats - rx_last_odd; tail++ (mod NUM_SLOTS); count++. Commit effective the cycle after the last beat, same cycle mem_* carries the last write.
- frame_avail = (count!=0); frame_slot = head; frame_len = len[head]. Registered.
- frame_release with count!=0: head++, count--. Release with count==0: ignored.
- Commit and release in same cycle: count unchanged, both pointers advance.
- Full-check uses count before that cycle's release (release does not rescue a frame starting same cycle).
- offset resets to 0 on every return to IDLE. drop_cnt saturates at all-ones.
- rst mid-frame: partial frame discarded, no commit, counters cleared, mem_en=0 next cycle.
- rx_valid beats in IDLE with no start condition do not exist: every beat in IDLE starts a frame.

Test Plan:
- Single 64-byte frame (32 beats, even) into empty ring -> 32 writes addr 0..31, we=11; next cycle frame_avail=1, frame_slot=0, frame_len=64, slot_count=1.
- 61-byte frame (31 beats, rx_last_odd=1) -> last write addr 30 we=01; frame_len=61.
- Fill 8 frames, no release; 9th frame -> no mem_en, drop_cnt=1, slot_count=8; release -> frame_slot=1, slot_count=7; 10th frame written at {slot 0, 0}.
- 1030-beat frame -> 1024 writes, remainder swallowed, drop_cnt+1, no commit; next frame starts at same tail offset 0.
- Frame with rx_err=1 on last beat -> drop_cnt+1, slot_count unchanged; release while empty -> no change.
- Commit and release same cycle with count=3 -> count stays 3, head and tail both advance; rst asserted mid-frame at beat 10 -> all outputs 0, next frame at addr 0.
